// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RISC-V core front end.
//   fetch_state_t  - state encoding of the instruction-fetch FSM
//   NOP_INSTR      - canonical NOP (addi x0, x0, 0) loaded on reset
//   OP_*           - major opcodes (instr[6:0]) recognised by the main decoder
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle of the fetch stage's memory and pipeline signals.
//   imem_req/imem_addr/imem_ack/imem_rdata - instruction memory handshake
//   instr/pc/pc_plus4/instr_valid/instr_ready - instruction to the decoder
//   redirect/redirect_target - next-PC override for the accepted instruction
//   fetch_err - sticky misaligned-target error
// Modport master is the fetch stage; slave is memory plus downstream.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            fetch_err;

    modport master (
        output imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, fetch_err,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, pc, pc_plus4, instr_valid, fetch_err,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/instr_fetch_pc_next_sel.sv
// pc_next_sel: combinational next-PC select for the fetch stage.
//   pc              in  address of the instruction being accepted
//   redirect        in  take redirect_target instead of pc+4
//   redirect_target in  branch/jump target
//   next_pc         out selected next fetch address (modulo 2^XLEN)
//   misaligned      out next_pc is not word aligned
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    always_comb begin
        next_pc    = redirect ? redirect_target : pc + XLEN'(4);
        misaligned = |next_pc[1:0];
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage. Owns the PC, issues one instruction
// memory request at a time and holds the fetched word until downstream
// accepts it, then fetches pc+4 or the redirect target.
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   master side of instr_fetch_if (memory handshake, instruction out,
//         redirect in, fetch_err out)
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    fetch_state_t    state_reg;
    logic            idle_wait_reg;
    logic [XLEN-1:0] fetch_pc_reg;
    logic            req_reg;
    logic [31:0]     instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic            valid_reg;
    logic            err_reg;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc              (pc_reg),
        .redirect        (bus.redirect),
        .redirect_target (bus.redirect_target),
        .next_pc         (next_pc),
        .misaligned      (next_misaligned)
    );

    // All outputs come straight from registers, so the asynchronous reset
    // drops imem_req immediately and abandons any pending ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idle_wait_reg <= 1'b0;
            fetch_pc_reg  <= RESET_PC;
            req_reg       <= 1'b0;
            instr_reg     <= NOP_INSTR;
            pc_reg        <= RESET_PC;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Spend one full cycle in IDLE after reset release so the
                    // first request appears on the second rising edge.
                    if (idle_wait_reg) begin
                        state_reg    <= REQ;
                        req_reg      <= 1'b1;
                        fetch_pc_reg <= RESET_PC;
                    end else begin
                        idle_wait_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        instr_reg <= bus.imem_rdata;
                        pc_reg    <= fetch_pc_reg;
                        req_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    // redirect/redirect_target matter only on the accept edge.
                    if (valid_reg && bus.instr_ready) begin
                        valid_reg <= 1'b0;
                        if (next_misaligned) begin
                            err_reg   <= 1'b1;
                            state_reg <= ERR;
                        end else begin
                            fetch_pc_reg <= next_pc;
                            req_reg      <= 1'b1;
                            state_reg    <= REQ;
                        end
                    end
                end
                ERR: begin
                    // Terminal until reset.
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.imem_req    = req_reg;
    assign bus.imem_addr   = fetch_pc_reg;
    assign bus.instr       = instr_reg;
    assign bus.pc          = pc_reg;
    assign bus.pc_plus4    = pc_reg + XLEN'(4);
    assign bus.instr_valid = valid_reg;
    assign bus.fetch_err   = err_reg;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the RISC-V core: owns the program counter, issues one instruction-memory request at a time over a req/ack handshake, and holds the fetched word in an instruction register. The instruction register feeds the main decoder, which reads `instr[6:0]` as `op`. The stage advances to PC+4, or to the redirect target computed from the decoder's `branch`/`Jump` outcome, only when downstream accepts the current instruction.

## Interface
Parameters:
- `XLEN`, 32, datapath and address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  XLEN  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction register to the decoder and datapath.
- `pc`  out  XLEN  address of `instr`.
- `pc_plus4`  out  XLEN  `pc`+4, consumed by the JAL link write.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  downstream accepts `instr`.
- `redirect`  in  1  PCSrc = (branch & zero) | Jump for the accepted instruction.
- `redirect_target`  in  XLEN  PCTarget for the accepted instruction.
- `fetch_err`  out  1  sticky misaligned-target error.

## Operation
The stage is a four-state FSM: IDLE, REQ, HOLD, ERR.

- **IDLE**: entered on reset. Lasts one cycle after `rst_n` deasserts, then goes to REQ with `fetch_pc`=RESET_PC.
- **REQ**:
  - `imem_req`=1 and `imem_addr`=`fetch_pc`.
  - On `imem_ack`: capture `imem_rdata` into `instr`, set `pc`=`fetch_pc`, go to HOLD.
  - Without ack: stay in REQ with the address held.
- **HOLD**:
  - `instr_valid`=1; `instr`, `pc` and `pc_plus4` are stable.
  - On `instr_valid & instr_ready` (the accept): `next` = `redirect` ? `redirect_target` : `pc`+4.
  - If `next[1:0]`≠0, go to ERR. Otherwise set `fetch_pc`=`next` and go to REQ.
- **ERR**: `fetch_err`=1, `imem_req`=0, `instr_valid`=0. Only reset leaves this state.

Rules:
- `redirect` and `redirect_target` are sampled only on the accept cycle and are ignored at all other times.
- `imem_ack` outside REQ is ignored; `instr` is not modified.
- Only one request is outstanding at a time; there is no prefetch and no speculative fetch.
- Arithmetic is XLEN bits modulo 2^XLEN: PC 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- `pc_plus4` is combinational from the `pc` register.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n`=0): `imem_req`=0, `imem_addr`=RESET_PC, `instr`=32'h0000_0013 (NOP), `pc`=RESET_PC, `instr_valid`=0, `fetch_err`=0, state=IDLE.
- Reset mid-request: `imem_req` drops combinationally with reset and the pending ack is abandoned.
- First `imem_req` is asserted in the 2nd rising edge after `rst_n` deasserts; that edge enters REQ.
- Zero-wait memory (ack in the same cycle as req): accept at cycle t → REQ at t+1 → `instr_valid` at t+2. Sustained throughput is therefore 1 instruction per 2 cycles.
- An N-cycle ack delay adds N cycles to that latency.
- `instr_valid` falls in the cycle after the accept.
- If `instr_ready` is held low, HOLD lasts indefinitely with all outputs stable.
- `fetch_err` is asserted in the cycle after the accept of a misaligned redirect.

## Structure
- Shared package `riscv_pkg` holds:
  - `fetch_state_t` enum (IDLE, REQ, HOLD, ERR).
  - `NOP_INSTR`=32'h0000_0013.
  - Opcode constants used with the main decoder (`OP_JAL`, `OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_B`).
- One sub-module, `pc_next_sel`: combinational next-PC select (+4 vs redirect) plus the misalignment check. The FSM and registers stay in `instr_fetch`.

## Test plan
- **Reset then zero-wait memory, `instr_ready`=1:** `imem_addr` sequence 0x0, 0x4, 0x8, with `instr_valid` high every 2nd cycle and `pc` matching each address.
- **Ack delayed 3 cycles at 0x4:** `imem_req` and `imem_addr`=0x4 held for 4 cycles, with `instr_valid` low throughout; `instr`=`imem_rdata` sampled on the ack cycle.
- **`instr_ready`=0 for 5 cycles with `instr`=0x00500093 at `pc`=0x8:** outputs stable and no `imem_req`; on release, next fetch is at 0xC.
- **Accept of JAL at `pc`=0x10 with `redirect`=1, target 0x40:** next `imem_addr`=0x40 and `pc_plus4` was 0x14 during HOLD. `redirect`=1 while `instr_ready`=0 is ignored.
- **Redirect to 0x42:** `fetch_err`=1 next cycle, `imem_req` stays 0; `rst_n` pulse clears it and fetch restarts at RESET_PC.
- **`rst_n` asserted during REQ with ack pending:** `imem_req`=0 and `instr`=0x00000013 immediately; a late ack after release is ignored.
